hi_lo_ctrl: RTL and testbench
=============================

# hi_lo_ctrl

HI/LO register file and divide sequencer for the pipelined CPU's EX stage. It sits directly downstream of the 32-iteration restoring divider. It launches a DIVU by pulsing the divider's load strobe and steps the divider's `Signal` through 32 DIVU cycles, then one OUT cycle. It then captures the 64-bit result into HI (remainder) and LO (quotient), and serves MFHI/MFLO/MTHI/MTLO, stalling the pipeline while a divide is in flight.

## Interface
Parameters:
- `DIVU`, 6'd27: function code that starts an unsigned divide.
- `MFHI`, 6'd16: read HI.
- `MTHI`, 6'd17: write HI.
- `MFLO`, 6'd18: read LO.
- `MTLO`, 6'd19: write LO.
- `OUT`, 6'd63: divider output code.
- `ITER`, 32: number of divider iteration cycles.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `Signal`  in  6  function code from ALU control. Codes other than the five above are ignored.
- `writeData`  in  32  rs value for MTHI/MTLO.
- `divResult`  in  64  divider `dataOut`: [63:32] remainder, [31:0] quotient.
- `divSignal`  out  6  drives divider `Signal`: DIVU, OUT or 0.
- `divLoad`  out  1  one-cycle operand-load strobe to the divider's `reset` port. This is not the system reset.
- `busy`  out  1  divide in flight.
- `stall`  out  1  hold the pipeline; the current `Signal` is not accepted.
- `dataOut`  out  32  HI or LO for MFHI/MFLO.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. State is 2 bits. A 6-bit iteration counter `cnt` runs alongside.
- IDLE
  - `Signal`==DIVU at the clock edge → LOAD.
  - `Signal`==MTHI → hi<=writeData. `Signal`==MTLO → lo<=writeData.
  - `divSignal`=0, `divLoad`=0.
- LOAD (1 cycle)
  - `divLoad`=1, `divSignal`=0; the divider samples its operands.
  - cnt<=0, then → RUN.
- RUN (exactly ITER cycles)
  - `divSignal`=DIVU, cnt increments each edge.
  - When cnt==ITER-1 at the edge → DONE.
- DONE (1 cycle)
  - `divSignal`=OUT, so the divider presents its final `divResult` combinationally.
  - At the edge: hi<=divResult[63:32], lo<=divResult[31:0], then → IDLE.
- `busy`=1 in LOAD, RUN and DONE; 0 in IDLE.
- `stall` = busy AND `Signal` in {DIVU, MFHI, MFLO, MTHI, MTLO}. It is combinational.
  - A stalled code has no effect. The pipeline holds it, and it is accepted in the first IDLE cycle.
- `dataOut` is combinational:
  - hi when `Signal`==MFHI and not busy.
  - lo when `Signal`==MFLO and not busy.
  - Otherwise holds 0.
- Divide-by-zero is not detected here; whatever the divider produces is captured unchanged.

## Timing
- Reset (async assert, any state):
  - state=IDLE, cnt=0, hi=lo=0.
  - `divSignal`=0, `divLoad`=0, `busy`=0, `stall`=0, `dataOut`=0.
- Reset mid-divide: the divide is abandoned, HI/LO are cleared, and no OUT is issued.
- DIVU latency, counted from the accepting edge E0:
  - LOAD during cycle E0→E1.
  - RUN for cycles E1→E33.
  - DONE for cycle E33→E34.
  - hi/lo valid after E34, i.e. 34 cycles.
  - Back-to-back DIVU is accepted at E34 at the earliest.
- MFHI/MFLO in the cycle right after DONE return the new result; no extra bubble is needed.
- MTHI/MTLO take effect at the edge. An MFHI in the next cycle returns the written value.
- DIVU and MT* cannot coincide, since `Signal` is one code per cycle.
- `busy` and `stall` never glitch on `cnt` wrap, because cnt never wraps: its max is ITER-1.

## Test plan
- Reset then MFHI, MFLO → `dataOut`=0 both; `busy`=0, `stall`=0.
- With a behavioural divider model, DIVU 100/7 → `divLoad` is high for one cycle, `divSignal`=27 for exactly 32 cycles, then 63 for 1 cycle. After E34, hi=2 and lo=14; MFLO → 14.
- MFHI issued 5 cycles into a divide of 0xFFFFFFFF/0x10 → `stall`=1 until IDLE. It is then accepted and `dataOut`=0xF. hi keeps its prior value during the stall.
- MTHI 0xDEADBEEF, then next cycle MFHI → 0xDEADBEEF. MTLO 0x1234 while busy → stalled; lo unchanged until the divide completes, then the write is accepted.
- Assert `reset` at cycle 17 of RUN → immediately IDLE, `divSignal`=0, hi=lo=0. A following DIVU 9/3 → hi=0, lo=3.
- Back-to-back DIVU 50/5 then 51/5 held by stall → second starts at E34. Final hi=1, lo=10.

Source files
------------

// File: rtl/hi_lo_ctrl.sv
// hi_lo_ctrl: HI/LO register file plus the sequencer that drives the
// 32-iteration restoring divider (LOAD -> 32x DIVU -> OUT -> capture).
module hi_lo_ctrl #(
    parameter logic [5:0] DIVU = 6'd27,
    parameter logic [5:0] MFHI = 6'd16,
    parameter logic [5:0] MTHI = 6'd17,
    parameter logic [5:0] MFLO = 6'd18,
    parameter logic [5:0] MTLO = 6'd19,
    parameter logic [5:0] OUT  = 6'd63,
    parameter int         ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Signal,
    input  logic [31:0] writeData,
    input  logic [63:0] divResult,
    output logic [5:0]  divSignal,
    output logic        divLoad,
    output logic        busy,
    output logic        stall,
    output logic [31:0] dataOut,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Last RUN count; cnt stops here so it never wraps.
    localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_busy;
    logic        w_ours;

    assign w_busy = (r_state != S_IDLE);
    // Codes this block owns; anything else passes through unstalled.
    assign w_ours = (Signal == DIVU) || (Signal == MFHI) || (Signal == MFLO) ||
                    (Signal == MTHI) || (Signal == MTLO);

    // Sequencer FSM, iteration counter and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Signal == DIVU) r_state <= S_LOAD;
                    if (Signal == MTHI) r_hi <= writeData;
                    if (Signal == MTLO) r_lo <= writeData;
                end
                S_LOAD: begin
                    r_cnt   <= 6'd0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    // DONE: divider is presenting OUT, capture remainder/quotient.
                    r_hi    <= divResult[63:32];
                    r_lo    <= divResult[31:0];
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Divider control decoded from state.
    always_comb begin
        divSignal = 6'd0;
        divLoad   = 1'b0;
        case (r_state)
            S_LOAD:  divLoad   = 1'b1;
            S_RUN:   divSignal = DIVU;
            S_DONE:  divSignal = OUT;
            default: ;
        endcase
    end

    // Read mux for MFHI/MFLO; reads are only served once the divide has landed.
    always_comb begin
        dataOut = 32'd0;
        if (!w_busy && Signal == MFHI) dataOut = r_hi;
        if (!w_busy && Signal == MFLO) dataOut = r_lo;
    end

    assign busy  = w_busy;
    assign stall = w_busy && w_ours;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_hi_lo_ctrl.sv
// Self-checking bench for hi_lo_ctrl with a behavioural divider and
// a HI/LO reference model tracked as plain variables.
module tb_hi_lo_ctrl;

    localparam logic [5:0] C_DIVU = 6'd27;
    localparam logic [5:0] C_MFHI = 6'd16;
    localparam logic [5:0] C_MTHI = 6'd17;
    localparam logic [5:0] C_MFLO = 6'd18;
    localparam logic [5:0] C_MTLO = 6'd19;
    localparam logic [5:0] C_OUT  = 6'd63;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  Signal = 6'd0;
    logic [31:0] writeData = 32'd0;
    logic [63:0] divResult;
    logic [5:0]  divSignal;
    logic        divLoad, busy, stall;
    logic [31:0] dataOut, hi, lo;

    int vecs = 0;
    int errs = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Divider model: operands latched on load strobe, result shown only on OUT.
    logic [31:0] opA = 32'd1, opB = 32'd1, dA = 32'd0, dB = 32'd1;
    always @(posedge clk) if (divLoad) begin dA <= opA; dB <= opB; end
    assign divResult = (divSignal == C_OUT) ? {dA % dB, dA / dB} : 64'hBAD0_BAD0_BAD0_BAD0;

    hi_lo_ctrl dut (
        .clk(clk), .reset(reset), .Signal(Signal), .writeData(writeData),
        .divResult(divResult), .divSignal(divSignal), .divLoad(divLoad),
        .busy(busy), .stall(stall), .dataOut(dataOut), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Full DIVU from an idle point; checks the strobe/code sequence and result.
    task automatic do_divu(input logic [31:0] a, input logic [31:0] b);
        int k;
        logic exp_ld;
        logic [5:0] exp_sig;
        opA = a; opB = b; Signal = C_DIVU;
        #4;
        vecs++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL divu_issue: stall=%b busy=%b want 0 0", stall, busy);
        end
        tick();
        Signal = 6'd0;
        k = 0;
        while (k < 100) begin
            #4;
            if (!busy) break;
            exp_ld  = (k == 0);
            exp_sig = (k == 0) ? 6'd0 : (k <= 32) ? C_DIVU : (k == 33) ? C_OUT : 6'h3F;
            vecs++;
            if (divLoad !== exp_ld || divSignal !== exp_sig || stall !== 1'b0) begin
                errs++;
                $display("FAIL divu_seq k=%0d: load=%b sig=%0d stall=%b want load=%b sig=%0d stall=0",
                         k, divLoad, divSignal, stall, exp_ld, exp_sig);
            end
            k++;
            tick();
        end
        vecs++;
        if (k != 34) begin
            errs++; $display("FAIL divu_latency: busy cycles %0d want 34", k);
        end
        m_hi = a % b; m_lo = a / b;
        vecs++;
        if (hi !== m_hi || lo !== m_lo) begin
            errs++; $display("FAIL divu_result %0d/%0d: hi=%h lo=%h want hi=%h lo=%h", a, b, hi, lo, m_hi, m_lo);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        vecs++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || stall !== 0 || divSignal !== 0 || divLoad !== 0 || dataOut !== 0) begin
            errs++; $display("FAIL reset_state: hi=%h lo=%h busy=%b stall=%b sig=%0d ld=%b do=%h want all 0",
                             hi, lo, busy, stall, divSignal, divLoad, dataOut);
        end
        tick(); tick();
        reset = 1'b0;
        Signal = C_MFHI;
        #4;
        vecs++;
        if (dataOut !== 0 || busy !== 0 || stall !== 0) begin
            errs++; $display("FAIL reset_mfhi: do=%h busy=%b stall=%b want 0 0 0", dataOut, busy, stall);
        end
        tick();
        Signal = C_MFLO;
        #4;
        vecs++;
        if (dataOut !== 0 || busy !== 0 || stall !== 0) begin
            errs++; $display("FAIL reset_mflo: do=%h busy=%b stall=%b want 0 0 0", dataOut, busy, stall);
        end
        tick();
        Signal = 6'd0;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_divu_basic();
        do_divu(32'd100, 32'd7);
        Signal = C_MFLO;
        #4;
        vecs++;
        if (dataOut !== 32'd14) begin
            errs++; $display("FAIL mflo_after_div: got %0d want 14", dataOut);
        end
        tick();
        Signal = C_MFHI;
        #4;
        vecs++;
        if (dataOut !== 32'd2) begin
            errs++; $display("FAIL mfhi_after_div: got %0d want 2", dataOut);
        end
        tick();
        Signal = 6'd0;
    endtask

    task automatic test_stall_mfhi();
        int n;
        logic [31:0] prior;
        prior = m_hi;
        opA = 32'hFFFF_FFFF; opB = 32'h10; Signal = C_DIVU;
        tick();
        Signal = 6'd0;
        repeat (5) tick();
        Signal = C_MFHI;
        n = 0;
        while (n < 60) begin
            #4;
            if (!busy) break;
            vecs++;
            if (stall !== 1'b1 || dataOut !== 32'd0 || (divSignal != C_OUT && hi !== prior)) begin
                errs++; $display("FAIL stall_mfhi n=%0d: stall=%b do=%h hi=%h want 1 0 %h", n, stall, dataOut, hi, prior);
            end
            n++;
            tick();
        end
        m_hi = 32'hF; m_lo = 32'h0FFF_FFFF;
        vecs++;
        if (n >= 60 || stall !== 1'b0 || dataOut !== m_hi || lo !== m_lo) begin
            errs++; $display("FAIL stall_release: n=%0d stall=%b do=%h lo=%h want stall=0 do=%h lo=%h",
                             n, stall, dataOut, lo, m_hi, m_lo);
        end
        tick();
        Signal = 6'd0;
    endtask

    task automatic test_mt();
        int n;
        Signal = C_MTHI; writeData = 32'hDEAD_BEEF;
        tick();
        m_hi = 32'hDEAD_BEEF;
        Signal = C_MFHI;
        #4;
        vecs++;
        if (dataOut !== m_hi) begin
            errs++; $display("FAIL mthi_mfhi: got %h want %h", dataOut, m_hi);
        end
        tick();
        // MTLO held during a divide of 20/3.
        opA = 32'd20; opB = 32'd3; Signal = C_DIVU;
        tick();
        Signal = C_MTLO; writeData = 32'h1234;
        n = 0;
        while (n < 60) begin
            #4;
            if (!busy) break;
            vecs++;
            if (stall !== 1'b1 || lo !== m_lo) begin
                errs++; $display("FAIL mtlo_stalled n=%0d: stall=%b lo=%h want 1 %h", n, stall, lo, m_lo);
            end
            n++;
            tick();
        end
        m_hi = 32'd2; m_lo = 32'd6;
        vecs++;
        if (n != 34 || lo !== m_lo || hi !== m_hi || stall !== 1'b0) begin
            errs++; $display("FAIL mtlo_divdone: n=%0d hi=%h lo=%h stall=%b want 34 %h %h 0", n, hi, lo, stall, m_hi, m_lo);
        end
        tick();
        Signal = 6'd0;
        m_lo = 32'h1234;
        vecs++;
        if (lo !== m_lo) begin
            errs++; $display("FAIL mtlo_accepted: lo=%h want %h", lo, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        opA = 32'd1000; opB = 32'd9; Signal = C_DIVU;
        tick();
        Signal = 6'd0;
        repeat (18) tick();
        vecs++;
        if (divSignal !== C_DIVU) begin
            errs++; $display("FAIL mid_run: sig=%0d want 27", divSignal);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (busy !== 0 || divSignal !== 0 || divLoad !== 0 || hi !== 0 || lo !== 0) begin
            errs++; $display("FAIL reset_mid: busy=%b sig=%0d ld=%b hi=%h lo=%h want all 0", busy, divSignal, divLoad, hi, lo);
        end
        tick();
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        repeat (20) begin
            #4;
            vecs++;
            if (divSignal !== 0 || busy !== 0) begin
                errs++; $display("FAIL no_out_after_reset: sig=%0d busy=%b want 0 0", divSignal, busy);
            end
            tick();
        end
        do_divu(32'd9, 32'd3);
    endtask

    task automatic test_back_to_back();
        int n;
        opA = 32'd50; opB = 32'd5; Signal = C_DIVU;
        tick();
        n = 0;
        while (n < 60) begin
            #4;
            if (n == 1) begin opA = 32'd51; opB = 32'd5; end
            if (!busy) break;
            vecs++;
            if (stall !== 1'b1) begin
                errs++; $display("FAIL b2b_stall n=%0d: stall=%b want 1", n, stall);
            end
            n++;
            tick();
        end
        vecs++;
        if (n != 34 || hi !== 32'd0 || lo !== 32'd10 || stall !== 1'b0) begin
            errs++; $display("FAIL b2b_first: n=%0d hi=%0d lo=%0d stall=%b want 34 0 10 0", n, hi, lo, stall);
        end
        tick();
        Signal = 6'd0;
        n = 0;
        while (n < 60) begin
            #4;
            if (!busy) break;
            n++;
            tick();
        end
        m_hi = 32'd1; m_lo = 32'd10;
        vecs++;
        if (n != 34 || hi !== m_hi || lo !== m_lo) begin
            errs++; $display("FAIL b2b_second: n=%0d hi=%0d lo=%0d want 34 1 10", n, hi, lo);
        end
        tick();
    endtask

    // Random mix of ops from idle, checked against m_hi/m_lo.
    task automatic test_random();
        int op;
        logic [31:0] d;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            d  = $urandom;
            case (op)
                0: do_divu($urandom, $urandom_range(1, 32'hFFFF));
                1: begin Signal = C_MTHI; writeData = d; tick(); m_hi = d; Signal = 6'd0; end
                2: begin Signal = C_MTLO; writeData = d; tick(); m_lo = d; Signal = 6'd0; end
                3, 4: begin
                    Signal = (op == 3) ? C_MFHI : C_MFLO;
                    #4;
                    vecs++;
                    if (dataOut !== ((op == 3) ? m_hi : m_lo) || stall !== 1'b0) begin
                        errs++; $display("FAIL rand_mf op=%0d: do=%h stall=%b want %h 0", op, dataOut, stall,
                                         (op == 3) ? m_hi : m_lo);
                    end
                    tick();
                    Signal = 6'd0;
                end
                default: begin
                    Signal = 6'($urandom_range(0, 15)); writeData = d;
                    #4;
                    vecs++;
                    if (busy !== 0 || stall !== 0 || dataOut !== 0) begin
                        errs++; $display("FAIL rand_other code=%0d: busy=%b stall=%b do=%h want 0", Signal, busy, stall, dataOut);
                    end
                    tick();
                    Signal = 6'd0;
                    vecs++;
                    if (hi !== m_hi || lo !== m_lo) begin
                        errs++; $display("FAIL rand_other_regs: hi=%h lo=%h want %h %h", hi, lo, m_hi, m_lo);
                    end
                end
            endcase
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_divu_basic();
        test_stall_mfhi();
        test_mt();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
